pll_cen_gen: RTL and testbench

Parametrised N-channel fractional clock-enable generator for the `sys/pll` area. Several derived rates come from one PLL output instead of one PLL per rate. Each channel runs a phase accumulator on the single fabric clock and emits one-cycle enable pulses at `f_refclk * inc / 2^ACC_W`. Increments can be reprogrammed at run time without glitches, a global `sync` phase-aligns all channels, and a `locked` flag reports when the rate configuration is stable.

---
 rtl/pll_cen_gen.sv | 130 +++++++++++++
 tb/tb_pll_cen_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: N-channel fractional clock-enable generator.
// Phase accumulators on one clock emit cen pulses at f*inc/2^ACC_W.
//
// Ports:
//   refclk, rst_n   single clock, async active-low reset
//   cfg_wr/addr/data  increment write; cfg_ack pulses next cycle
//   sync            zero all accumulators, flush pending increments
//   cen             per-channel one-cycle enable pulses
//   clk_sq          per-channel square outputs (PLL_CEN_SQ_EN), else 0
//   locked          no pending increments for LOCK_CYCLES cycles
// Optional feature macro: PLL_CEN_SQ_EN
module pll_cen_gen #(
  parameter int NUM_CLOCKS  = 3,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 256,
  localparam int AW =
    (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [ACC_W-1:0]      cfg_data,
  output logic                  cfg_ack,
  input  logic                  sync,
  output logic [NUM_CLOCKS-1:0] cen,
  output logic [NUM_CLOCKS-1:0] clk_sq,
  output logic                  locked
);

  localparam logic [15:0] LOCK_MAX =
    16'(LOCK_CYCLES);

  logic [ACC_W-1:0] acc  [NUM_CLOCKS];
  logic [ACC_W-1:0] inc  [NUM_CLOCKS];
  logic [ACC_W-1:0] pend [NUM_CLOCKS];
  logic [ACC_W:0]   sum  [NUM_CLOCKS];

  logic [NUM_CLOCKS-1:0] pend_v;
  logic [NUM_CLOCKS-1:0] carry;
  logic [NUM_CLOCKS-1:0] wr_hit;
  logic [NUM_CLOCKS-1:0] xfer;

  logic [15:0] cnt;
  logic        clr;

  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i]  = sum[i][ACC_W];
      wr_hit[i] = cfg_wr && (cfg_addr == AW'(i));
      // Swap only at a period boundary, or at once
      // when the channel is idle.
      xfer[i]   = pend_v[i] &&
                  (carry[i] || (inc[i] == '0));
    end
  end

  // Out-of-range addresses hit no channel.
  assign clr = sync || (|wr_hit);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc[i]  <= '0;
        inc[i]  <= '0;
        pend[i] <= '0;
      end
      pend_v <= '0;
      cen    <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (sync) begin
          acc[i] <= '0;
          cen[i] <= 1'b0;
          if (pend_v[i])
            inc[i] <= pend[i];
        end else begin
          acc[i] <= sum[i][ACC_W-1:0];
          cen[i] <= carry[i];
          if (xfer[i])
            inc[i] <= pend[i];
        end
        // A write in the same cycle as a transfer
        // re-arms the shadow with the new value.
        if (wr_hit[i]) begin
          pend[i]   <= cfg_data;
          pend_v[i] <= 1'b1;
        end else if (sync || xfer[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack <= 1'b0;
      cnt     <= '0;
      locked  <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr;
      if (clr)
        cnt <= '0;
      else if (cnt != LOCK_MAX)
        cnt <= cnt + 16'd1;
      // Gating on clr drops lock right after the event.
      locked <= !clr && (cnt == LOCK_MAX) &&
                (pend_v == '0);
    end
  end

`ifdef PLL_CEN_SQ_EN
  logic [NUM_CLOCKS-1:0] sq_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      sq_q <= '0;
    else if (sync)
      sq_q <= '0;
    else
      sq_q <= sq_q ^ carry;
  end

  assign clk_sq = sq_q;
`else
  assign clk_sq = '0;
`endif

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: directed bench for pll_cen_gen.
// Scoreboard of model outputs plus directed rate checks.
module tb_pll_cen_gen;

  localparam int N = 3;
  localparam int W = 8;
  localparam int L = 16;
  localparam int M = 1 << W;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       sync = 1'b0;
  logic       cfg_ack;
  logic       locked;
  logic [2:0] cen;
  logic [2:0] clk_sq;

  always #5 refclk = ~refclk;

  pll_cen_gen #(
    .NUM_CLOCKS (N),
    .ACC_W      (W),
    .LOCK_CYCLES(L)
  ) dut (
    .refclk  (refclk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_ack (cfg_ack),
    .sync    (sync),
    .cen     (cen),
    .clk_sq  (clk_sq),
    .locked  (locked)
  );

  typedef struct packed {
    logic [2:0] cen;
    logic [2:0] sq;
    logic       ack;
    logic       lk;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  int         m_acc [N];
  int         m_inc [N];
  int         m_pend[N];
  bit         m_pv  [N];
  int         m_cnt;
  logic [2:0] m_cen;
  logic [2:0] m_sq;
  logic       m_ack;
  logic       m_lk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
      m_pend[i] = 0;
      m_pv[i] = 1'b0;
    end
    m_cnt = 0;
    m_cen = '0;
    m_sq  = '0;
    m_ack = 1'b0;
    m_lk  = 1'b0;
  endtask

  task automatic model_step(input bit wr,
                            input int a,
                            input int d,
                            input bit sy);
    bit hit [N];
    bit any_hit;
    bit any_pv;
    bit clr;
    int s;
    bit c;
    bit x;
    any_hit = 1'b0;
    any_pv  = 1'b0;
    for (int i = 0; i < N; i++) begin
      hit[i] = wr && (a == i);
      any_hit |= hit[i];
      any_pv  |= m_pv[i];
    end
    clr  = sy || any_hit;
    m_lk = !clr && (m_cnt == L) && !any_pv;
    if (clr)
      m_cnt = 0;
    else if (m_cnt < L)
      m_cnt++;
    m_ack = wr;
    for (int i = 0; i < N; i++) begin
      s = m_acc[i] + m_inc[i];
      c = (s >= M);
      x = 1'b0;
      if (sy) begin
        m_acc[i] = 0;
        m_cen[i] = 1'b0;
        m_sq[i]  = 1'b0;
        if (m_pv[i]) m_inc[i] = m_pend[i];
      end else begin
        m_acc[i] = s % M;
        m_cen[i] = c;
        m_sq[i]  = m_sq[i] ^ c;
        x = m_pv[i] && (c || m_inc[i] == 0);
        if (x) m_inc[i] = m_pend[i];
      end
      if (hit[i]) begin
        m_pend[i] = d;
        m_pv[i]   = 1'b1;
      end else if (sy || x) begin
        m_pv[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit wr,
                     input int a,
                     input int d,
                     input bit sy);
    exp_t e;
    cfg_wr   = wr;
    cfg_addr = 2'(a);
    cfg_data = 8'(d);
    sync     = sy;
    model_step(wr, a, d, sy);
    e.cen = m_cen;
`ifdef PLL_CEN_SQ_EN
    e.sq  = m_sq;
`else
    e.sq  = '0;
`endif
    e.ack = m_ack;
    e.lk  = m_lk;
    sb.push_back(e);
    @(posedge refclk);
    #1;
    e = sb.pop_front();
    chk("cen",    32'(cen),     32'(e.cen));
    chk("clk_sq", 32'(clk_sq),  32'(e.sq));
    chk("ack",    32'(cfg_ack), 32'(e.ack));
    chk("locked", 32'(locked),  32'(e.lk));
    cfg_wr = 1'b0;
    sync   = 1'b0;
    t++;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int first_lk;
    int lastp;
    int np;
    int bad;
    int gaps[$];

    // 1: reset and lock-up
    model_reset();
    repeat (5) @(posedge refclk);
    #1;
    chk("rst_cen",    32'(cen),    0);
    chk("rst_ack",    32'(cfg_ack), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sq",     32'(clk_sq), 0);
    rst_n = 1'b1;
    first_lk = 0;
    for (int k = 1; k <= 24; k++) begin
      idle();
      if (locked && first_lk == 0)
        first_lk = k;
    end
    chk("lock_rise_cycle", 32'(first_lk), 17);

    // 2: ch0 = 64, period 4
    cyc(1'b1, 0, 64, 1'b0);
    chk("ack_after_wr", 32'(cfg_ack), 1);
    np = 0;
    bad = 0;
    lastp = -1;
    repeat (20) begin
      idle();
      if (cen[0]) begin
        if (lastp >= 0 && t - lastp != 4) bad++;
        lastp = t;
        np++;
      end
    end
    chk("ch0_64_pulses", 32'(np), 4);
    chk("ch0_64_gaps", 32'(bad), 0);

    // 3: switch to 128 mid-period
    np = 0;
    while (!cen[0] && np < 8) begin
      idle();
      np++;
    end
    chk("ch0_pulse_seen", 32'(cen[0]), 1);
    lastp = t;
    idle();
    cyc(1'b1, 0, 128, 1'b0);
    repeat (10) begin
      idle();
      if (cen[0]) begin
        gaps.push_back(t - lastp);
        lastp = t;
      end
    end
    chk("rate_chg_n", 32'(gaps.size()), 5);
    chk("rate_chg_first", 32'(gaps[0]), 4);
    bad = 0;
    for (int i = 1; i < gaps.size(); i++)
      if (gaps[i] != 2) bad++;
    chk("rate_chg_rest", 32'(bad), 0);

    // 4: ch1 = 85 from acc = 0
    cyc(1'b1, 1, 85, 1'b0);
    idle();
    np = 0;
    bad = 0;
    lastp = -1;
    repeat (M) begin
      idle();
      if (cen[1]) begin
        if (lastp >= 0 &&
            (t - lastp < 3 || t - lastp > 4))
          bad++;
        lastp = t;
        np++;
      end
    end
    chk("ch1_85_pulses", 32'(np), 85);
    chk("ch1_85_gaps", 32'(bad), 0);

    // 5: ch0 = ch2 = 40, then sync
    cyc(1'b1, 0, 40, 1'b0);
    repeat (3) idle();
    cyc(1'b1, 2, 40, 1'b0);
    repeat (5) idle();
    cyc(1'b0, 0, 0, 1'b1);
    chk("sync_cen0", 32'(cen), 0);
    chk("sync_lk0", 32'(locked), 0);
    np = 0;
    bad = 0;
    for (int k = 1; k <= 60; k++) begin
      idle();
      if (cen[0] !== cen[2]) bad++;
      if (cen[0]) np++;
      if (k <= 16 && locked) bad++;
    end
    chk("sync_align", 32'(bad), 0);
    chk("sync_ch0_pulses", 32'(np), 9);

    // 6: out-of-range write, then async reset
    repeat (20) idle();
    chk("pre_oor_locked", 32'(locked), 1);
    cyc(1'b1, 3, 200, 1'b0);
    chk("oor_ack", 32'(cfg_ack), 1);
    bad = 0;
    repeat (4) begin
      idle();
      if (!locked) bad++;
    end
    chk("oor_locked", 32'(bad), 0);
    np = 0;
    while (cen == '0 && np < 10) begin
      idle();
      np++;
    end
    chk("pulse_before_rst", 32'(cen != '0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_cen",    32'(cen),     0);
    chk("arst_sq",     32'(clk_sq),  0);
    chk("arst_ack",    32'(cfg_ack), 0);
    chk("arst_locked", 32'(locked),  0);
    chk("sb_empty",    32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
